// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: raster timing for an RGB parallel LCD (480x272 by default).
// Runs on the divided PLL pixel clock. It walks an h/v counter through
// active, front porch, sync and back porch, then issues pixel requests to
// the pixel source. DE, HSYNC, VSYNC and RGB leave on one common edge,
// two cycles after the counter state that produced them.
//
// Optional build macro: LCD_TEST_PATTERN_EN. When it is defined, pix_rgb is
// ignored and an internal 8-bar colour generator drives RGB with the same
// latency.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | counters held at 0, outputs quiet, waiting for en
// SCAN  | counters running; en is only looked at on the last pixel
module lcd_timing_gen #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 43,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 8,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 12,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 11
) (
  input  logic          PixelClk,
  input  logic          nRST,
  input  logic          en,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_req,
  input  logic [15:0]   pix_rgb,
  output logic          LCD_HSYNC,
  output logic          LCD_VSYNC,
  output logic          LCD_DE,
  output logic [4:0]    LCD_R,
  output logic [5:0]    LCD_G,
  output logic [4:0]    LCD_B,
  output logic          frame_start,
  output logic          running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Sync pins sit at the inverse of their active level when not in a pulse.
  localparam logic HS_ACT = (HS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic VS_ACT = (VS_POL != 0) ? 1'b1 : 1'b0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t        state_q;
  logic [CW-1:0] h_q, v_q;
  logic          running_q, frame_start_q;

  // Stage 0 registers: request plus the counter position it came from.
  logic          pix_req_q;
  logic [CW-1:0] pix_x_q, pix_y_q;
  logic          scan_s0_q;
  logic [CW-1:0] h_s0_q, v_s0_q;

  // Stage 1 registers: what the panel pins see.
  logic          de_q, hsync_q, vsync_q;
  logic [15:0]   rgb_q;

  logic          h_last, v_last;
  logic          pix_req_d;
  logic          hs_win_d, vs_win_d;
  logic [15:0]   rgb_src_d;

  // Position decode of the live counters and of the stage-0 copy.
  always_comb begin
    h_last    = (h_q == H_LAST);
    v_last    = (v_q == V_LAST);
    pix_req_d = (state_q == ST_SCAN) && (h_q < H_ACT_C) && (v_q < V_ACT_C);
    hs_win_d  = scan_s0_q && (h_s0_q >= HS_FIRST) && (h_s0_q <= HS_LAST);
    vs_win_d  = scan_s0_q && (v_s0_q >= VS_FIRST) && (v_s0_q <= VS_LAST);
  end

  // Scan FSM with the h/v counters; en only matters on the last pixel of a frame.
  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      state_q       <= ST_IDLE;
      h_q           <= '0;
      v_q           <= '0;
      running_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          h_q <= '0;
          v_q <= '0;
          if (en) begin
            state_q       <= ST_SCAN;
            running_q     <= 1'b1;
            frame_start_q <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (h_last) begin
            h_q <= '0;
            if (v_last) begin
              v_q <= '0;
              if (en) begin
                frame_start_q <= 1'b1;
              end else begin
                state_q   <= ST_IDLE;
                running_q <= 1'b0;
              end
            end else begin
              v_q <= v_q + ONE;
            end
          end else begin
            h_q <= h_q + ONE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // Stage 0: register the request; pix_x/pix_y keep the last requested pixel.
  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      pix_req_q <= 1'b0;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
      scan_s0_q <= 1'b0;
      h_s0_q    <= '0;
      v_s0_q    <= '0;
    end else begin
      pix_req_q <= pix_req_d;
      if (pix_req_d) begin
        pix_x_q <= h_q;
        pix_y_q <= v_q;
      end
      scan_s0_q <= (state_q == ST_SCAN);
      h_s0_q    <= h_q;
      v_s0_q    <= v_q;
    end
  end

`ifdef LCD_TEST_PATTERN_EN
  // Eight equal vertical bars across the active width, indexed by pix_x*8/H_ACTIVE.
  localparam logic [CW+2:0] BAR_DIV = (CW+3)'(H_ACTIVE);

  logic [CW+2:0] x_times8;
  logic [2:0]    bar_idx;
  logic          unused_pix_rgb;

  assign x_times8       = {pix_x_q, 3'b000};
  assign bar_idx        = 3'(x_times8 / BAR_DIV);
  assign unused_pix_rgb = ^pix_rgb;

  // Bar colour lookup, RGB565 at full scale.
  always_comb begin
    rgb_src_d = 16'h0000;
    case (bar_idx)
      3'd0: rgb_src_d = 16'hFFFF;
      3'd1: rgb_src_d = 16'hFFE0;
      3'd2: rgb_src_d = 16'h07FF;
      3'd3: rgb_src_d = 16'h07E0;
      3'd4: rgb_src_d = 16'hF81F;
      3'd5: rgb_src_d = 16'hF800;
      3'd6: rgb_src_d = 16'h001F;
      default: rgb_src_d = 16'h0000;
    endcase
  end
`else
  // The external pixel source returns data in the cycle after the request.
  assign rgb_src_d = pix_rgb;
`endif

  // Stage 1: pin registers; RGB forced to 0 outside the active area.
  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      de_q    <= 1'b0;
      hsync_q <= ~HS_ACT;
      vsync_q <= ~VS_ACT;
      rgb_q   <= 16'h0000;
    end else begin
      de_q    <= pix_req_q;
      hsync_q <= hs_win_d ? HS_ACT : ~HS_ACT;
      vsync_q <= vs_win_d ? VS_ACT : ~VS_ACT;
      rgb_q   <= pix_req_q ? rgb_src_d : 16'h0000;
    end
  end

  assign pix_req     = pix_req_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign LCD_DE      = de_q;
  assign LCD_HSYNC   = hsync_q;
  assign LCD_VSYNC   = vsync_q;
  assign LCD_R       = rgb_q[15:11];
  assign LCD_G       = rgb_q[10:5];
  assign LCD_B       = rgb_q[4:0];
  assign frame_start = frame_start_q;
  assign running     = running_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Testbench for lcd_timing_gen on a scaled-down panel (48x12 active,
// 60x21 total) so that whole frames stay short.
module tb_lcd_timing_gen;

  localparam int HA = 48, HFP = 4, HSY = 3, HBP = 5;
  localparam int VA = 12, VFP = 3, VSY = 2, VBP = 4;
  localparam int CW = 11;
  localparam int HT = HA + HFP + HSY + HBP;   // 60
  localparam int VT = VA + VFP + VSY + VBP;   // 21
  localparam int FRAME = HT * VT;             // 1260

  logic          PixelClk = 1'b0;
  logic          nRST = 1'b0;
  logic          en = 1'b1;
  logic [CW-1:0] pix_x, pix_y;
  logic          pix_req;
  logic [15:0]   pix_rgb;
  logic          LCD_HSYNC, LCD_VSYNC, LCD_DE;
  logic [4:0]    LCD_R;
  logic [5:0]    LCD_G;
  logic [4:0]    LCD_B;
  logic          frame_start, running;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_fs = 0;

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(0), .VS_POL(0), .CW(CW)
  ) dut (
    .PixelClk(PixelClk), .nRST(nRST), .en(en),
    .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req), .pix_rgb(pix_rgb),
    .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC), .LCD_DE(LCD_DE),
    .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B),
    .frame_start(frame_start), .running(running)
  );

  always #5 PixelClk = ~PixelClk;
  always @(posedge PixelClk) cyc <= cyc + 1;

  // Pixel source: data for the requested pixel is presented while pix_req is
  // high and is captured on the following edge; junk otherwise.
  always_comb begin
    pix_rgb = 16'hFFFF;
    if (pix_req) pix_rgb = {pix_y[4:0], pix_x[5:0], pix_y[4:0]};
  end

  function automatic logic [15:0] exp_rgb(input int h, input int v);
    logic [CW-1:0] hx, vy;
    int bar;
    hx = CW'(h);
    vy = CW'(v);
`ifdef LCD_TEST_PATTERN_EN
    bar = (h * 8) / HA;
    case (bar)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
`else
    bar = 0;
    return {vy[4:0], hx[5:0], vy[4:0]} | 16'(bar);
`endif
  endfunction

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({pix_req, pix_x, pix_y, frame_start, running, LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B}
        !== {1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 6'd0, 5'd0}) begin
      errors++;
      $display("FAIL %s: req=%b x=%0d y=%0d fs=%b run=%b de=%b hs=%b vs=%b rgb=%h, required req=0 x=0 y=0 fs=0 run=0 de=0 hs=1 vs=1 rgb=0000",
               tag, pix_req, pix_x, pix_y, frame_start, running, LCD_DE, LCD_HSYNC, LCD_VSYNC, {LCD_R, LCD_G, LCD_B});
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    en   = 1'b1;
    repeat (5) @(negedge PixelClk);
    check_idle_outputs("reset_values");
    nRST = 1'b1;
    @(negedge PixelClk);
    checks++;
    if ({frame_start, running} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release_start: fs=%b run=%b, required fs=1 run=1", frame_start, running);
    end
    t_fs = cyc;
    @(negedge PixelClk);
    checks++;
    if ({frame_start, running} !== 2'b01) begin
      errors++;
      $display("FAIL reset_release_pulse: fs=%b run=%b, required fs=0 run=1", frame_start, running);
    end
  endtask

  task automatic test_frame_timing();
    int t, o1, o2, h1, v1, h2, v2;
    logic [CW-1:0] ex_x, ex_y;
    logic er, ed, ehs, evs, efs;
    logic [15:0] ergb;
    logic [43:0] act_v, exp_v;
    logic [43:0] first_act, first_exp;
    int mism, first_cyc;
    int de_cyc, de_rise, de_rise_cyc, hs_fall, hs_start, hs_len_bad, hs_rel_chk, hs_rel_bad;
    int vs_start, vs_run, vs_len_bad, fs_cnt;
    logic prev_de, prev_hs, prev_vs;
    ex_x = '0; ex_y = '0;
    mism = 0; first_cyc = -1; first_act = '0; first_exp = '0;
    de_cyc = 0; de_rise = 0; de_rise_cyc = -100000; hs_fall = 0; hs_start = 0;
    hs_len_bad = 0; hs_rel_chk = 0; hs_rel_bad = 0;
    vs_start = 0; vs_run = 0; vs_len_bad = 0; fs_cnt = 0;
    prev_de = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge PixelClk);
      t  = cyc;
      o1 = t - t_fs - 1;
      h1 = o1 % HT;
      v1 = (o1 / HT) % VT;
      er = (h1 < HA) && (v1 < VA);
      if (er) begin
        ex_x = CW'(h1);
        ex_y = CW'(v1);
      end
      o2   = t - t_fs - 2;
      h2   = o2 % HT;
      v2   = (o2 / HT) % VT;
      ed   = (h2 < HA) && (v2 < VA);
      ehs  = !((h2 >= HA + HFP) && (h2 <= HA + HFP + HSY - 1));
      evs  = !((v2 >= VA + VFP) && (v2 <= VA + VFP + VSY - 1));
      ergb = ed ? exp_rgb(h2, v2) : 16'h0000;
      efs  = (((t - t_fs) % FRAME) == 0);
      exp_v = {er, ex_x, ex_y, ed, ehs, evs, ergb, efs, 1'b1};
      act_v = {pix_req, pix_x, pix_y, LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B, frame_start, running};
      if (act_v !== exp_v) begin
        if (mism == 0) begin
          first_cyc = o2;
          first_act = act_v;
          first_exp = exp_v;
        end
        mism++;
      end
      if (LCD_DE === 1'b1) de_cyc++;
      if (LCD_DE === 1'b1 && !prev_de) begin
        de_rise++;
        de_rise_cyc = t;
      end
      if (LCD_HSYNC === 1'b0 && prev_hs) begin
        hs_fall++;
        hs_start = t;
        if (t - de_rise_cyc < HT) begin
          hs_rel_chk++;
          if (t - de_rise_cyc != HA + HFP) hs_rel_bad++;
        end
      end
      if (LCD_HSYNC === 1'b1 && !prev_hs && (t - hs_start != HSY)) hs_len_bad++;
      if (LCD_VSYNC === 1'b0 && prev_vs) vs_start = t;
      if (LCD_VSYNC === 1'b1 && !prev_vs) begin
        vs_run++;
        if (t - vs_start != VSY * HT) vs_len_bad++;
      end
      if (frame_start === 1'b1) fs_cnt++;
      prev_de = (LCD_DE === 1'b1);
      prev_hs = (LCD_HSYNC !== 1'b0);
      prev_vs = (LCD_VSYNC !== 1'b0);
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL raster_model: %0d cycles differ, first at pin offset %0d: got %h required %h ({req,x,y,de,hs,vs,rgb,fs,run})",
               mism, first_cyc, first_act, first_exp);
    end
    checks++;
    if (fs_cnt != 2) begin errors++; $display("FAIL frame_start_period: %0d pulses in 2 frames, required 2", fs_cnt); end
    checks++;
    if (de_cyc != 2 * HA * VA) begin errors++; $display("FAIL de_cycles: %0d, required %0d", de_cyc, 2 * HA * VA); end
    checks++;
    if (de_rise != 2 * VA) begin errors++; $display("FAIL de_lines: %0d, required %0d", de_rise, 2 * VA); end
    checks++;
    if (hs_fall != 2 * VT) begin errors++; $display("FAIL hsync_count: %0d, required %0d", hs_fall, 2 * VT); end
    checks++;
    if (hs_len_bad != 0) begin errors++; $display("FAIL hsync_width: %0d pulses not %0d wide, required 0", hs_len_bad, HSY); end
    checks++;
    if (hs_rel_chk != 2 * VA || hs_rel_bad != 0) begin
      errors++;
      $display("FAIL hsync_after_de: checked %0d bad %0d, required checked %0d bad 0", hs_rel_chk, hs_rel_bad, 2 * VA);
    end
    checks++;
    if (vs_run != 2 || vs_len_bad != 0) begin
      errors++;
      $display("FAIL vsync_width: runs %0d bad %0d, required runs 2 bad 0", vs_run, vs_len_bad);
    end
  endtask

  task automatic test_en_drop();
    int guard, f, run_bad, vs_low, idle_bad;
    guard = 0;
    @(negedge PixelClk);
    while (frame_start !== 1'b1 && guard < 3 * FRAME) begin
      @(negedge PixelClk);
      guard++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL en_drop_wait_fs: frame_start=%b, required 1 within %0d cycles", frame_start, 3 * FRAME);
      return;
    end
    f = cyc;
    while (cyc < f + 5 * HT + 17) @(negedge PixelClk);
    en = 1'b0;
    run_bad = 0;
    vs_low = 0;
    while (cyc < f + FRAME - 1) begin
      @(negedge PixelClk);
      if (running !== 1'b1 || frame_start !== 1'b0) run_bad++;
      if (LCD_VSYNC === 1'b0) vs_low++;
    end
    checks++;
    if (run_bad != 0) begin errors++; $display("FAIL en_drop_keeps_running: %0d bad cycles, required 0", run_bad); end
    checks++;
    if (vs_low != VSY * HT) begin errors++; $display("FAIL en_drop_frame_completes: vsync low %0d, required %0d", vs_low, VSY * HT); end
    @(negedge PixelClk);
    checks++;
    if ({running, frame_start} !== 2'b00) begin
      errors++;
      $display("FAIL en_drop_stop: run=%b fs=%b, required run=0 fs=0", running, frame_start);
    end
    idle_bad = 0;
    repeat (200) begin
      @(negedge PixelClk);
      if ({LCD_DE, frame_start, running, pix_req, LCD_HSYNC, LCD_VSYNC} !== 6'b000011) idle_bad++;
    end
    checks++;
    if (idle_bad != 0) begin errors++; $display("FAIL en_drop_idle: %0d bad cycles, required 0", idle_bad); end
    en = 1'b1;
    @(negedge PixelClk);
    checks++;
    if ({frame_start, running} !== 2'b11) begin
      errors++;
      $display("FAIL en_restart: fs=%b run=%b, required fs=1 run=1", frame_start, running);
    end
    t_fs = cyc;
    @(negedge PixelClk);
    checks++;
    if ({pix_req, pix_x, pix_y} !== {1'b1, 11'd0, 11'd0}) begin
      errors++;
      $display("FAIL en_restart_origin: req=%b x=%0d y=%0d, required req=1 x=0 y=0", pix_req, pix_x, pix_y);
    end
    repeat (2) @(negedge PixelClk);
    checks++;
    if ({LCD_DE, LCD_R, LCD_G, LCD_B} !== {1'b1, exp_rgb(1, 0)}) begin
      errors++;
      $display("FAIL en_restart_pixel1: de=%b rgb=%h, required de=1 rgb=%h", LCD_DE, {LCD_R, LCD_G, LCD_B}, exp_rgb(1, 0));
    end
  endtask

  task automatic test_reset_mid();
    while (cyc < t_fs + 5 * HT + 20) @(negedge PixelClk);
    checks++;
    if ({LCD_DE, LCD_R, LCD_G, LCD_B} !== {1'b1, exp_rgb(18, 5)}) begin
      errors++;
      $display("FAIL pre_reset_pixel: de=%b rgb=%h, required de=1 rgb=%h", LCD_DE, {LCD_R, LCD_G, LCD_B}, exp_rgb(18, 5));
    end
    nRST = 1'b0;
    @(negedge PixelClk);
    check_idle_outputs("reset_mid_line");
    nRST = 1'b1;
    @(negedge PixelClk);
    checks++;
    if ({frame_start, running} !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_restart: fs=%b run=%b, required fs=1 run=1", frame_start, running);
    end
    t_fs = cyc;
    @(negedge PixelClk);
    checks++;
    if ({pix_req, pix_x, pix_y} !== {1'b1, 11'd0, 11'd0}) begin
      errors++;
      $display("FAIL reset_mid_origin: req=%b x=%0d y=%0d, required req=1 x=0 y=0", pix_req, pix_x, pix_y);
    end
  endtask

`ifdef LCD_TEST_PATTERN_EN
  task automatic test_pattern();
    int xs[10];
    logic [15:0] cols[10];
    xs   = '{0, 5, 6, 12, 18, 24, 30, 36, 42, 47};
    cols = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
             16'hF81F, 16'hF800, 16'h001F, 16'h0000, 16'h0000};
    for (int k = 0; k < 10; k++) begin
      while (cyc < t_fs + 2 + xs[k]) @(negedge PixelClk);
      checks++;
      if ({LCD_DE, LCD_R, LCD_G, LCD_B} !== {1'b1, cols[k]}) begin
        errors++;
        $display("FAIL test_pattern_x%0d: de=%b rgb=%h, required de=1 rgb=%h", xs[k], LCD_DE, {LCD_R, LCD_G, LCD_B}, cols[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame_timing();
    test_en_drop();
    test_reset_mid();
`ifdef LCD_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Generates the RGB-LCD raster timing for the 480x272 panel: HSYNC, VSYNC and DE.
- Issues pixel coordinates/requests to the pixel source and registers RGB565 data out to the panel pins.
- Clocked by the divided pixel clock (CLKOUTD) of the on-chip rPLL; sits directly downstream of the PLL and upstream of the LCD pins.

Parameters:
- H_ACTIVE, 480, visible pixels per line
- H_FP, 8, horizontal front porch (clocks)
- H_SYNC, 4, HSYNC width (clocks)
- H_BP, 43, horizontal back porch (clocks)
- V_ACTIVE, 272, visible lines per frame
- V_FP, 8, vertical front porch (lines)
- V_SYNC, 4, VSYNC width (lines)
- V_BP, 12, vertical back porch (lines)
- HS_POL, 0, HSYNC active level
- VS_POL, 0, VSYNC active level
- CW, 11, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- PixelClk  in  1  pixel clock (rPLL CLKOUTD)
- nRST  in  1  synchronous active-low reset
- en  in  1  scan enable, acted on only at frame boundary
- pix_x  out  CW  active-area column of current request
- pix_y  out  CW  active-area row of current request
- pix_req  out  1  pixel (pix_x,pix_y) requested this cycle
- pix_rgb  in  16  RGB565 data, valid exactly one cycle after pix_req
- LCD_HSYNC  out  1  horizontal sync
- LCD_VSYNC  out  1  vertical sync
- LCD_DE  out  1  data enable
- LCD_R  out  5  red
- LCD_G  out  6  green
- LCD_B  out  5  blue
- frame_start  out  1  one-cycle pulse at h=0, v=0
- running  out  1  scan active

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (535). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (296).
- Line order: active, FP, sync, BP. Frame order is the same, counted in lines.
- Reset (nRST low at PixelClk edge):
  - h_cnt=0, v_cnt=0, running=0, pix_req=0, pix_x=0, pix_y=0, frame_start=0, LCD_DE=0.
  - LCD_HSYNC=~HS_POL, LCD_VSYNC=~VS_POL, RGB=0.
  - Reset mid-frame aborts immediately; there is no partial-frame completion.
- States:
  - IDLE: counters held at 0, outputs at reset values.
    - IDLE->SCAN when en=1 is sampled. Counting starts the next cycle at h=0, v=0, and frame_start pulses in that cycle.
  - SCAN: h_cnt increments each cycle and wraps at H_TOTAL-1 -> 0.
    - On h wrap, v_cnt increments and wraps at V_TOTAL-1 -> 0.
    - At the last pixel of a frame (h=H_TOTAL-1, v=V_TOTAL-1), en is sampled:
      - en=0: go to IDLE.
      - en=1: continue, and frame_start pulses at the new h=0, v=0.
    - en changes mid-frame have no effect until that boundary.
- Stage 0 (combinational from counters, registered once):
  - pix_req = (h<H_ACTIVE)&&(v<V_ACTIVE).
  - pix_x=h, pix_y=v while pix_req=1. They hold their last values otherwise.
- Stage 1, one cycle after stage 0:
  - LCD_DE = delayed pix_req.
  - LCD_HSYNC active when delayed h is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - LCD_VSYNC active when delayed v is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. It spans whole lines, changing at the h=0 delayed cycle.
  - RGB registered from pix_rgb when the delayed pix_req=1, else 0.
  - Net: DE, syncs and RGB all appear on the same PixelClk edge, 2 cycles after counter state. The pixel source has exactly 1 cycle of latency.
- running=1 in SCAN, else 0.
- All arithmetic is unsigned CW-bit. Compare against parameters; no free-running overflow.

Optional Feature:
- LCD_TEST_PATTERN_EN.
- Defined: pix_rgb is ignored. RGB comes from an internal 8-bar colour generator indexed by pix_x*8/H_ACTIVE, in the order white, yellow, cyan, green, magenta, red, blue, black. Full-scale components (R=31/0, G=63/0, B=31/0). Timing and latency are unchanged.
- Undefined: RGB comes from pix_rgb as above.

Test Plan:
- nRST low 5 cycles with en=1 -> all outputs at reset values. Release -> frame_start pulses one cycle later, running=1.
- Free run 2 frames -> frame_start period = 158360 cycles.
  - LCD_DE high 480 cycles per line on 272 lines per frame.
  - LCD_HSYNC low 4 cycles, starting 488 cycles after DE rise.
  - LCD_VSYNC low for 4x535 cycles.
- pix_rgb driven as {pix_y[4:0], pix_x[5:0], pix_y[4:0]} one cycle after pix_req -> LCD_R/G/B match the expected pixel whenever LCD_DE=1, and read 0 when LCD_DE=0.
- en dropped at line 100 -> scan completes through v=295, h=534. Then running=0, LCD_DE stays 0, and there is no further frame_start. Re-raise en -> restart at h=0, v=0.
- nRST low mid-line (h=200, v=50) -> next cycle all outputs at reset values. After release, scan restarts from 0,0.
- With LCD_TEST_PATTERN_EN: line 0 pixels 0..59 = {31,63,31}, pixels 420..479 = {0,0,0}, bar transitions every 60 pixels.
